// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: two request/ack ports plus the shared data-memory bus
interface dmem_port_arbiter_if;
    logic        req0, req1, we0, we1;
    logic [15:0] adr0, adr1, wdat0, wdat1;
    logic        ack0, ack1;
    logic [15:0] rdat0, rdat1;
    logic [15:0] main_mem_read_adr, main_mem_write_adr, main_mem_write_dat, main_mem_dat;
    logic        main_mem_write;
    modport master (
        output req0, req1, we0, we1, adr0, adr1, wdat0, wdat1, main_mem_dat,
        input  ack0, ack1, rdat0, rdat1,
        input  main_mem_read_adr, main_mem_write_adr, main_mem_write_dat, main_mem_write
    );
    modport slave (
        input  req0, req1, we0, we1, adr0, adr1, wdat0, wdat1, main_mem_dat,
        output ack0, ack1, rdat0, rdat1,
        output main_mem_read_adr, main_mem_write_adr, main_mem_write_dat, main_mem_write
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single data-memory port between the CPU (port 0) and I/O/DMA (port 1)
module dmem_port_arbiter #(
    parameter bit RR = 1'b1
) (
    input logic clk,
    input logic rst_n,
    dmem_port_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2;
    logic [1:0]  state_q, state_d, ack_q, ack_d, cand;
    logic        gnt_q, gnt_d, last_q, last_d, we_q, we_d, win, go;
    logic [15:0] adr_q, adr_d, wdat_q, wdat_d, rdat0_q, rdat0_d, rdat1_q, rdat1_d;
    always_comb begin
        // the port just served still holds req while it sees ack, so mask it out in DONE
        cand    = {bus.req1, bus.req0} & ((state_q == DONE) ? ~(2'b01 << gnt_q) : 2'b11);
        win     = &cand ? (RR ? ~last_q : 1'b0) : cand[1];
        go      = |cand && state_q != ACCESS;
        state_d = go ? ACCESS : (state_q == ACCESS ? DONE : IDLE);
        gnt_d   = go ? win : gnt_q;
        last_d  = go ? win : last_q;
        adr_d   = go ? (win ? bus.adr1 : bus.adr0) : adr_q;
        wdat_d  = go ? (win ? bus.wdat1 : bus.wdat0) : wdat_q;
        we_d    = go && (win ? bus.we1 : bus.we0);
        ack_d   = (state_q == ACCESS) ? (2'b01 << gnt_q) : 2'b00;
        rdat0_d = (state_q == ACCESS && !we_q && !gnt_q) ? bus.main_mem_dat : rdat0_q;
        rdat1_d = (state_q == ACCESS && !we_q && gnt_q) ? bus.main_mem_dat : rdat1_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ack_q   <= 2'b00;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat0_q <= '0;
            rdat1_q <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdat0_q <= rdat0_d;
            rdat1_q <= rdat1_d;
        end
    end
    assign bus.ack0               = ack_q[0];
    assign bus.ack1               = ack_q[1];
    assign bus.rdat0              = rdat0_q;
    assign bus.rdat1              = rdat1_q;
    assign bus.main_mem_read_adr  = adr_q;
    assign bus.main_mem_write_adr = adr_q;
    assign bus.main_mem_write_dat = wdat_q;
    assign bus.main_mem_write     = we_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed and randomized checks of the round-robin (dut 0) and fixed-priority (dut 1) arbiters
module tb_dmem_port_arbiter;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    dmem_port_arbiter_if b_rr();
    dmem_port_arbiter_if b_fp();
    dmem_port_arbiter #(.RR(1'b1)) u_rr (.clk(clk), .rst_n(rst_n), .bus(b_rr));
    dmem_port_arbiter #(.RR(1'b0)) u_fp (.clk(clk), .rst_n(rst_n), .bus(b_fp));
    logic        req [2][2], we [2][2], ack [2][2], mw [2];
    logic [15:0] adr [2][2], wdat [2][2], rdat [2][2], mra [2], mwa [2], mwd [2];
    logic [15:0] mem [2][65536];
    logic        pl_en = 1'b0;
    int          pl_d = 0;
    logic [15:0] pl_a = '0, pl_v = '0;
    int          checks = 0, errors = 0;
    logic        rr_last;
    assign b_rr.req0 = req[0][0];  assign b_rr.req1 = req[0][1];
    assign b_rr.we0 = we[0][0];    assign b_rr.we1 = we[0][1];
    assign b_rr.adr0 = adr[0][0];  assign b_rr.adr1 = adr[0][1];
    assign b_rr.wdat0 = wdat[0][0]; assign b_rr.wdat1 = wdat[0][1];
    assign b_rr.main_mem_dat = mem[0][b_rr.main_mem_read_adr];
    assign b_fp.req0 = req[1][0];  assign b_fp.req1 = req[1][1];
    assign b_fp.we0 = we[1][0];    assign b_fp.we1 = we[1][1];
    assign b_fp.adr0 = adr[1][0];  assign b_fp.adr1 = adr[1][1];
    assign b_fp.wdat0 = wdat[1][0]; assign b_fp.wdat1 = wdat[1][1];
    assign b_fp.main_mem_dat = mem[1][b_fp.main_mem_read_adr];
    assign ack[0][0] = b_rr.ack0;   assign ack[0][1] = b_rr.ack1;
    assign rdat[0][0] = b_rr.rdat0; assign rdat[0][1] = b_rr.rdat1;
    assign mra[0] = b_rr.main_mem_read_adr; assign mwa[0] = b_rr.main_mem_write_adr;
    assign mwd[0] = b_rr.main_mem_write_dat; assign mw[0] = b_rr.main_mem_write;
    assign ack[1][0] = b_fp.ack0;   assign ack[1][1] = b_fp.ack1;
    assign rdat[1][0] = b_fp.rdat0; assign rdat[1][1] = b_fp.rdat1;
    assign mra[1] = b_fp.main_mem_read_adr; assign mwa[1] = b_fp.main_mem_write_adr;
    assign mwd[1] = b_fp.main_mem_write_dat; assign mw[1] = b_fp.main_mem_write;
    // memory commits writes on the falling edge; preload shares the same process
    always @(negedge clk) begin
        if (pl_en) mem[pl_d][pl_a] <= pl_v;
        if (b_rr.main_mem_write) mem[0][b_rr.main_mem_write_adr] <= b_rr.main_mem_write_dat;
        if (b_fp.main_mem_write) mem[1][b_fp.main_mem_write_adr] <= b_fp.main_mem_write_dat;
    end
    task automatic step;
        @(negedge clk);
        #1;
    endtask
    task automatic preload(input int d, input logic [15:0] a, input logic [15:0] v);
        pl_d = d; pl_a = a; pl_v = v; pl_en = 1'b1;
        step;
        pl_en = 1'b0;
    endtask
    task automatic wait_ack(input int d, output int got);
        got = -1;
        for (int c = 0; c < 8 && got < 0; c++) begin
            step;
            if (ack[d][0]) got = 0;
            else if (ack[d][1]) got = 1;
        end
    endtask
    function automatic logic [15:0] pool_adr(input int s);
        return (s == 0) ? 16'h0000 : (s == 7) ? 16'hFFFF : 16'h0200 + 16'(s);
    endfunction
    task automatic test_reset;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                req[d][p] = 1'b0; we[d][p] = 1'b0; adr[d][p] = '0; wdat[d][p] = '0;
            end
        step;
        step;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (ack[d][0] !== 1'b0 || ack[d][1] !== 1'b0) begin errors++; $display("FAIL reset_ack dut%0d: got %b%b want 00", d, ack[d][1], ack[d][0]); end
            checks++;
            if (rdat[d][0] !== 16'h0 || rdat[d][1] !== 16'h0) begin errors++; $display("FAIL reset_rdat dut%0d: got %h/%h want 0000", d, rdat[d][0], rdat[d][1]); end
            checks++;
            if (mra[d] !== 16'h0 || mwa[d] !== 16'h0 || mwd[d] !== 16'h0) begin errors++; $display("FAIL reset_bus dut%0d: got %h %h %h want zeros", d, mra[d], mwa[d], mwd[d]); end
            checks++;
            if (mw[d] !== 1'b0) begin errors++; $display("FAIL reset_write dut%0d: got %b want 0", d, mw[d]); end
        end
        rst_n = 1'b1;
        rr_last = 1'b1;
        step;
    endtask
    task automatic test_read;
        preload(0, 16'h0010, 16'hBEEF);
        adr[0][0] = 16'h0010; we[0][0] = 1'b0; req[0][0] = 1'b1;
        step;
        checks++;
        if (mra[0] !== 16'h0010) begin errors++; $display("FAIL rd_adr: got %h want 0010", mra[0]); end
        checks++;
        if (mw[0] !== 1'b0 || ack[0][0] !== 1'b0) begin errors++; $display("FAIL rd_access: write %b ack0 %b want 0 0", mw[0], ack[0][0]); end
        step;
        checks++;
        if (ack[0][0] !== 1'b1 || ack[0][1] !== 1'b0) begin errors++; $display("FAIL rd_ack: got ack0 %b ack1 %b want 1 0", ack[0][0], ack[0][1]); end
        checks++;
        if (rdat[0][0] !== 16'hBEEF) begin errors++; $display("FAIL rd_data: got %h want beef", rdat[0][0]); end
        req[0][0] = 1'b0;
        rr_last = 1'b0;
        step;
        checks++;
        if (ack[0][0] !== 1'b0) begin errors++; $display("FAIL rd_ack_pulse: got %b want 0", ack[0][0]); end
    endtask
    task automatic test_write_read;
        int nw = 0, got = -1;
        adr[0][1] = 16'hFFFF; wdat[0][1] = 16'h1234; we[0][1] = 1'b1; req[0][1] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step;
            if (mw[0]) nw++;
            if (ack[0][1] && got < 0) begin got = c; req[0][1] = 1'b0; end
        end
        checks++;
        if (got != 1) begin errors++; $display("FAIL wr_ack_latency: got step %0d want 1", got); end
        checks++;
        if (nw != 1) begin errors++; $display("FAIL wr_pulse: write high %0d cycles want 1", nw); end
        checks++;
        if (mem[0][16'hFFFF] !== 16'h1234) begin errors++; $display("FAIL wr_mem: got %h want 1234", mem[0][16'hFFFF]); end
        checks++;
        if (mwa[0] !== 16'hFFFF || mwd[0] !== 16'h1234) begin errors++; $display("FAIL wr_hold: got %h %h want ffff 1234", mwa[0], mwd[0]); end
        rr_last = 1'b1;
        we[0][1] = 1'b0; req[0][1] = 1'b1;
        wait_ack(0, got);
        checks++;
        if (got != 1) begin errors++; $display("FAIL rb_ack: got port %0d want 1", got); end
        checks++;
        if (rdat[0][1] !== 16'h1234) begin errors++; $display("FAIL rb_data: got %h want 1234", rdat[0][1]); end
        checks++;
        if (rdat[0][0] !== 16'hBEEF) begin errors++; $display("FAIL rb_hold0: got %h want beef", rdat[0][0]); end
        req[0][1] = 1'b0;
        step;
    endtask
    task automatic test_rr_tie;
        int n = 0, t_prev = 0;
        logic exp_p, p;
        exp_p = ~rr_last;
        adr[0][0] = 16'h0010; adr[0][1] = 16'hFFFF; we[0][0] = 1'b0; we[0][1] = 1'b0;
        req[0][0] = 1'b1; req[0][1] = 1'b1;
        for (int c = 0; c < 24 && n < 4; c++) begin
            step;
            checks++;
            if (ack[0][0] && ack[0][1]) begin errors++; $display("FAIL rr_dual_ack: step %0d got 11 want one-hot", c); end
            if (ack[0][0] || ack[0][1]) begin
                p = ack[0][1];
                checks++;
                if (p !== exp_p) begin errors++; $display("FAIL rr_order: access %0d got port %0d want %0d", n, p, exp_p); end
                if (n > 0) begin
                    checks++;
                    if (c - t_prev != 2) begin errors++; $display("FAIL rr_spacing: got %0d want 2", c - t_prev); end
                end
                checks++;
                if (rdat[0][p] !== (p ? 16'h1234 : 16'hBEEF)) begin errors++; $display("FAIL rr_data: port %0d got %h", p, rdat[0][p]); end
                t_prev = c; rr_last = p; exp_p = ~p; n++;
                if (n == 4) begin req[0][0] = 1'b0; req[0][1] = 1'b0; end
            end
        end
        checks++;
        if (n != 4) begin errors++; $display("FAIL rr_count: got %0d acks want 4", n); end
        step;
    endtask
    task automatic test_fixed_prio;
        int got;
        logic [15:0] w;
        for (int r = 0; r < 3; r++) begin
            w = 16'($urandom);
            // a lone port-0 access first, so a round-robin arbiter would now favour port 1
            adr[1][0] = 16'h0040 + 16'(r); we[1][0] = 1'b0; req[1][0] = 1'b1;
            wait_ack(1, got);
            checks++;
            if (got != 0) begin errors++; $display("FAIL fp_solo: round %0d got port %0d want 0", r, got); end
            req[1][0] = 1'b0;
            step;
            adr[1][1] = 16'h0050 + 16'(r); we[1][1] = 1'b1; wdat[1][1] = w;
            req[1][0] = 1'b1; req[1][1] = 1'b1;
            wait_ack(1, got);
            checks++;
            if (got != 0) begin errors++; $display("FAIL fp_tie: round %0d got port %0d want 0", r, got); end
            req[1][0] = 1'b0;
            wait_ack(1, got);
            checks++;
            if (got != 1) begin errors++; $display("FAIL fp_after: round %0d got port %0d want 1", r, got); end
            req[1][1] = 1'b0;
            step;
            checks++;
            if (mem[1][16'h0050 + 16'(r)] !== w) begin errors++; $display("FAIL fp_mem: round %0d got %h want %h", r, mem[1][16'h0050 + 16'(r)], w); end
        end
    endtask
    task automatic test_held;
        int n = 0, t_prev = 0;
        adr[0][0] = 16'h0010; we[0][0] = 1'b0; req[0][0] = 1'b1;
        for (int c = 0; c < 20 && n < 3; c++) begin
            step;
            if (ack[0][0]) begin
                if (n > 0) begin
                    checks++;
                    if (c - t_prev != 3) begin errors++; $display("FAIL held_spacing: got %0d want 3", c - t_prev); end
                end
                checks++;
                if (rdat[0][0] !== 16'hBEEF) begin errors++; $display("FAIL held_data: got %h want beef", rdat[0][0]); end
                t_prev = c; n++;
                if (n == 3) req[0][0] = 1'b0;
            end
        end
        checks++;
        if (n != 3) begin errors++; $display("FAIL held_count: got %0d acks want 3", n); end
        rr_last = 1'b0;
        step;
    endtask
    task automatic test_random;
        logic [15:0] refm [8];
        logic [15:0] lastrd [2];
        bit pend [2], seen [2], pwe [2];
        int slot [2], waitc [2];
        for (int s = 0; s < 8; s++) begin
            refm[s] = 16'($urandom);
            preload(0, pool_adr(s), refm[s]);
        end
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; seen[p] = 1'b0; slot[p] = 0; waitc[p] = 0; pwe[p] = 1'b0; lastrd[p] = '0;
        end
        for (int c = 0; c < 600; c++) begin
            step;
            checks++;
            if (ack[0][0] && ack[0][1]) begin errors++; $display("FAIL rnd_dual_ack: step %0d got 11 want one-hot", c); end
            for (int p = 0; p < 2; p++) begin
                if (ack[0][p]) begin
                    checks++;
                    if (!pend[p]) begin errors++; $display("FAIL rnd_spurious: port %0d got ack 1 want 0", p); end
                    else begin
                        rr_last = (p == 1);
                        if (pwe[p]) refm[slot[p]] = wdat[0][p];
                        else begin
                            checks++;
                            if (rdat[0][p] !== refm[slot[p]]) begin errors++; $display("FAIL rnd_rdata: port %0d adr %h got %h want %h", p, pool_adr(slot[p]), rdat[0][p], refm[slot[p]]); end
                            lastrd[p] = refm[slot[p]]; seen[p] = 1'b1;
                        end
                        pend[p] = 1'b0; req[0][p] = 1'b0;
                    end
                end else if (pend[p]) begin
                    waitc[p]++;
                    checks++;
                    if (waitc[p] > 8) begin errors++; $display("FAIL rnd_timeout: port %0d waited %0d want <=8", p, waitc[p]); pend[p] = 1'b0; req[0][p] = 1'b0; end
                end
                if (seen[p]) begin
                    checks++;
                    if (rdat[0][p] !== lastrd[p]) begin errors++; $display("FAIL rnd_hold: port %0d got %h want %h", p, rdat[0][p], lastrd[p]); end
                end
                if (!pend[p] && c < 560 && $urandom_range(1) == 1) begin
                    slot[p] = $urandom_range(7); pwe[p] = 1'($urandom_range(1));
                    adr[0][p] = pool_adr(slot[p]); we[0][p] = pwe[p]; wdat[0][p] = 16'($urandom);
                    req[0][p] = 1'b1; pend[p] = 1'b1; waitc[p] = 0;
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (pend[p]) begin errors++; $display("FAIL rnd_drain: port %0d got pending want idle", p); end
        end
        for (int s = 0; s < 8; s++) begin
            checks++;
            if (mem[0][pool_adr(s)] !== refm[s]) begin errors++; $display("FAIL rnd_mem: adr %h got %h want %h", pool_adr(s), mem[0][pool_adr(s)], refm[s]); end
        end
    endtask
    task automatic test_reset_mid_access;
        preload(0, 16'h0300, 16'hAAAA);
        adr[0][0] = 16'h0300; wdat[0][0] = 16'h5555; we[0][0] = 1'b1; req[0][0] = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (mw[0] !== 1'b1) begin errors++; $display("FAIL rst_pre_write: got %b want 1", mw[0]); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mw[0] !== 1'b0 || mra[0] !== 16'h0 || mwa[0] !== 16'h0 || mwd[0] !== 16'h0) begin errors++; $display("FAIL rst_bus: got %b %h %h %h want zeros", mw[0], mra[0], mwa[0], mwd[0]); end
        req[0][0] = 1'b0;
        step;
        checks++;
        if (mem[0][16'h0300] !== 16'hAAAA) begin errors++; $display("FAIL rst_mem: got %h want aaaa", mem[0][16'h0300]); end
        checks++;
        if (ack[0][0] !== 1'b0 || ack[0][1] !== 1'b0 || rdat[0][0] !== 16'h0 || rdat[0][1] !== 16'h0) begin errors++; $display("FAIL rst_outs: ack %b%b rdat %h/%h want zeros", ack[0][1], ack[0][0], rdat[0][0], rdat[0][1]); end
        step;
        rst_n = 1'b1;
        rr_last = 1'b1;
        step;
    endtask
    task automatic test_first_tie;
        adr[0][0] = 16'h0300; adr[0][1] = 16'h0010; we[0][0] = 1'b0; we[0][1] = 1'b0;
        req[0][0] = 1'b1; req[0][1] = 1'b1;
        step;
        checks++;
        if (mra[0] !== (rr_last ? 16'h0300 : 16'h0010) || ack[0][0] !== 1'b0 || ack[0][1] !== 1'b0) begin errors++; $display("FAIL tie_access: adr %h ack %b%b want 0300 00", mra[0], ack[0][1], ack[0][0]); end
        step;
        checks++;
        if (ack[0][0] !== 1'b1 || ack[0][1] !== 1'b0 || rdat[0][0] !== 16'hAAAA) begin errors++; $display("FAIL tie_first: ack %b%b rdat0 %h want 01 aaaa", ack[0][1], ack[0][0], rdat[0][0]); end
        req[0][0] = 1'b0;
        step;
        step;
        checks++;
        if (ack[0][1] !== 1'b1 || ack[0][0] !== 1'b0 || rdat[0][1] !== 16'hBEEF) begin errors++; $display("FAIL tie_second: ack %b%b rdat1 %h want 10 beef", ack[0][1], ack[0][0], rdat[0][1]); end
        req[0][1] = 1'b0;
        step;
    endtask
    initial begin
        test_reset;
        test_read;
        test_write_read;
        test_rr_tie;
        test_fixed_prio;
        test_held;
        test_random;
        test_reset_mid_access;
        test_first_tie;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
